// File: rtl/alu_ops_pkg.sv
// Opcode constants and result-select decode shared by the Simple-RISC ALU units.
// Opcodes not listed here (SUB, MUL, DIV, OR, shifts, NEG, NOT) belong to sibling units.
package alu_ops_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00101;
  localparam logic [4:0] OP_ADDI = 5'b01101;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_ANDI = 5'b01110;
  localparam logic [4:0] OP_INC  = 5'b11101;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ADD  = 2'd1,
    SEL_AND  = 2'd2,
    SEL_INC  = 2'd3
  } res_sel_e;

  // PC increment takes priority over whatever the opcode field holds.
  function automatic res_sel_e decode_sel(input logic inc_pc, input logic [4:0] op);
    res_sel_e sel;
    sel = SEL_NONE;
    if (inc_pc)                          sel = SEL_INC;
    else if (op == OP_ADD || op == OP_ADDI) sel = SEL_ADD;
    else if (op == OP_AND || op == OP_ANDI) sel = SEL_AND;
    else if (op == OP_INC)                  sel = SEL_INC;
    return sel;
  endfunction

endpackage

// File: rtl/rca32.sv
// Ripple-carry adder built from a chain of per-bit full adders.
// Carry-out is the carry leaving the top bit of the chain.
module rca32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = c[W];

endmodule

// File: rtl/add_inc_and_unit.sv
// Registered ADD/ADDI, AND/ANDI, INC and PC-increment unit between the A/B
// operand registers and the Z register. Upper half of z is always zero here.
module add_inc_and_unit
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [4:0]         opcode,
  input  logic               inc_pc,
  output logic [2*WIDTH-1:0] z,
  output logic               cout,
  output logic               out_valid
);

  // Handshake: in_valid is sampled on every rising edge with no backpressure;
  // out_valid is high for exactly one cycle per accepted operation, and z/cout
  // hold their last value whenever out_valid is low.

  logic [WIDTH-1:0]   add_sum;
  logic               add_co;
  logic [WIDTH-1:0]   inc_sum;
  logic               inc_co;
  logic [WIDTH-1:0]   and_res;
  logic [WIDTH-1:0]   res_lo;
  logic               res_c;
  res_sel_e           sel;

  logic [2*WIDTH-1:0] z_d, z_q;
  logic               cout_d, cout_q;
  logic               out_valid_d, out_valid_q;

  rca32 #(.W(WIDTH)) u_add (
    .a    (a_in),
    .b    (b_in),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_co)
  );

  // Increment reuses the adder structure with a zero addend and carry-in of 1.
  rca32 #(.W(WIDTH)) u_inc (
    .a    (b_in),
    .b    ({WIDTH{1'b0}}),
    .cin  (1'b1),
    .sum  (inc_sum),
    .cout (inc_co)
  );

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_and
      assign and_res[i] = a_in[i] & b_in[i];
    end
  endgenerate

  assign sel = decode_sel(inc_pc, opcode);

  always_comb begin
    res_lo = '0;
    res_c  = 1'b0;
    case (sel)
      SEL_ADD: begin
        res_lo = add_sum;
        res_c  = add_co;
      end
      SEL_AND: res_lo = and_res;
      SEL_INC: begin
        res_lo = inc_sum;
        res_c  = inc_co;
      end
      default: begin
        res_lo = '0;
        res_c  = 1'b0;
      end
    endcase
  end

  always_comb begin
    z_d         = z_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      z_d    = {{WIDTH{1'b0}}, res_lo};
      cout_d = res_c;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      z_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      z_q         <= z_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign z         = z_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_inc_and_unit.sv
// Scoreboard bench for add_inc_and_unit: directed corner cases followed by
// randomized traffic, checked against an arithmetic reference model.
module tb_add_inc_and_unit;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [4:0]  opcode;
  logic        inc_pc;
  logic [63:0] z;
  logic        cout;
  logic        out_valid;

  int checks;
  int errors;

  // expected {cout, z}
  logic [64:0] exp_q[$];
  logic [64:0] last_exp;

  add_inc_and_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .a_in      (a_in),
    .b_in      (b_in),
    .opcode    (opcode),
    .inc_pc    (inc_pc),
    .z         (z),
    .cout      (cout),
    .out_valid (out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model from the operation table, plain 33-bit arithmetic
  function automatic logic [64:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op, input logic pc);
    logic [32:0] s;
    if (pc)                                   s = {1'b0, b} + 33'd1;
    else if (op == 5'b00101 || op == 5'b01101) s = {1'b0, a} + {1'b0, b};
    else if (op == 5'b00111 || op == 5'b01110) s = {1'b0, a & b};
    else if (op == 5'b11101)                   s = {1'b0, b} + 33'd1;
    else                                       s = 33'd0;
    return {s[32], 32'h0, s[31:0]};
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got cout=%0b z=%h, expected cout=%0b z=%h",
               name, act[64], act[63:0], req[64], req[63:0]);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] op, input logic pc);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    opcode   = op;
    inc_pc   = pc;
    exp_q.push_back(ref_model(a, b, op, pc));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_in     = $urandom;
      b_in     = $urandom;
      opcode   = 5'($urandom_range(0, 31));
      inc_pc   = 1'($urandom_range(0, 1));
    end
  endtask

  // monitor / scoreboard: samples on the falling edge
  always @(negedge clk) begin
    if (clr) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got out_valid=1 z=%h, expected no result", z);
        end else begin
          last_exp = exp_q.pop_front();
          check("result", {cout, z}, last_exp);
        end
      end else begin
        check("hold", {cout, z}, last_exp);
      end
    end
  end

  logic [31:0] ra, rb;
  logic [4:0]  rop;
  logic        rpc;

  initial begin
    checks   = 0;
    errors   = 0;
    last_exp = '0;
    clr      = 1'b1;
    in_valid = 1'b1;
    a_in     = 32'hDEAD_BEEF;
    b_in     = 32'hFFFF_FFFF;
    opcode   = 5'b00101;
    inc_pc   = 1'b0;

    // asynchronous reset before any clock edge
    #1 clr = 1'b0;
    #1;
    check("reset_async", {cout, z}, 65'd0);
    check("reset_valid", {64'd0, out_valid}, 65'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 clr = 1'b1;

    // directed cases
    drive(32'h0000_0005, 32'h0000_0007, 5'b00101, 1'b0);
    drive(32'hFFFF_FFFF, 32'h0000_0002, 5'b01101, 1'b0);
    drive(32'hF0F0_1234, 32'h0FF0_FFFF, 5'b00111, 1'b0);
    drive(32'hF0F0_1234, 32'h0FF0_FFFF, 5'b01110, 1'b0);
    drive(32'h1234_5678, 32'hFFFF_FFFF, 5'b11101, 1'b0);
    drive(32'hAAAA_AAAA, 32'h0000_0010, 5'b00111, 1'b1);
    idle(3);
    drive(32'h1111_1111, 32'h2222_2222, 5'b00110, 1'b0);
    drive(32'h0000_0003, 32'h0000_0004, 5'b00101, 1'b0);
    idle(1);

    // reset pulse while an operation is pending: its result must never appear
    drive(32'h0000_0100, 32'h0000_0200, 5'b00101, 1'b0);
    #2;
    clr = 1'b0;
    in_valid = 1'b0;
    void'(exp_q.pop_back());
    last_exp = '0;
    #1;
    check("reset_mid", {cout, z}, 65'd0);
    check("reset_mid_valid", {64'd0, out_valid}, 65'd0);
    @(posedge clk);
    #1 clr = 1'b1;
    idle(2);
    drive(32'h0000_0009, 32'h0000_0001, 5'b01101, 1'b0);
    idle(1);

    // randomized traffic with corner-value bias
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'hFFFF_FFFF;
        1: ra = 32'h0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = 32'hFFFF_FFFF;
        1: rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rop = 5'b00101;
        1: rop = 5'b01101;
        2: rop = 5'b00111;
        3: rop = 5'b01110;
        4: rop = 5'b11101;
        default: rop = 5'($urandom_range(0, 31));
      endcase
      rpc = ($urandom_range(0, 7) == 0);
      drive(ra, rb, rop, rpc);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
